// File: rtl/chan_pkg.sv
// Shared types and constants for the DMA sound channel fetch path.
package chan_pkg;
  localparam int AW          = 22;
  localparam int IDXW        = 5;
  localparam int QDEPTH_LOG2 = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  // Byte phase within an address triplet: hi, mid, lo
  localparam logic [1:0] PH_HI  = 2'd0;
  localparam logic [1:0] PH_MID = 2'd1;
  localparam logic [1:0] PH_LO  = 2'd2;
endpackage

// File: rtl/chan_addr_fifo.sv
// Small synchronous address FIFO; a pop in the same cycle frees room for a push when full.
module chan_addr_fifo
  import chan_pkg::*;
#(
  parameter int W          = chan_pkg::AW,
  parameter int DEPTH_LOG2 = chan_pkg::QDEPTH_LOG2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]        mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign rdata = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    do_rd    = pop && !empty;
    do_wr    = push && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
  end
endmodule

// File: rtl/chan_fetch_sched.sv
// Assembles 3-byte sample addresses, queues them and runs one memory fetch at a time,
// returning each byte tagged with its ordinal within the current frame.
module chan_fetch_sched
  import chan_pkg::*;
#(
  parameter int AW          = chan_pkg::AW,
  parameter int QDEPTH_LOG2 = chan_pkg::QDEPTH_LOG2,
  parameter int IDXW        = chan_pkg::IDXW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            sync_stb,
  input  logic [7:0]      in_data,
  input  logic            in_stb_addr,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic            mem_rdy,
  input  logic [7:0]      mem_rdata,
  output logic [7:0]      smp_data,
  output logic [IDXW-1:0] smp_idx,
  output logic            smp_stb,
  output logic            ovf,
  output logic            late,
  input  logic            clr_flags
);
  localparam int HIW = AW - 16;

  logic [1:0]      phase_q, phase_d, phase_cur;
  logic [HIW-1:0]  hi_q, hi_d;
  logic [7:0]      mid_q, mid_d;
  logic            push;
  logic [AW-1:0]   push_addr;

  logic            pop, q_full, q_empty;
  logic [AW-1:0]   q_head;

  fetch_state_e    state_q;
  logic            mem_req_q;
  logic [AW-1:0]   mem_addr_q;
  logic [7:0]      smp_data_q;
  logic [IDXW-1:0] smp_idx_q, ord_q, ord_base;
  logic            smp_stb_q, smp_fire;

  logic            ovf_q, ovf_d, late_q, late_d;

  // A frame strobe restarts the triplet, including a byte arriving in the same cycle.
  always_comb begin
    phase_cur = sync_stb ? PH_HI : phase_q;
    phase_d   = phase_cur;
    hi_d      = hi_q;
    mid_d     = mid_q;
    push      = 1'b0;
    if (in_stb_addr) begin
      case (phase_cur)
        PH_HI: begin
          hi_d    = in_data[HIW-1:0];
          phase_d = PH_MID;
        end
        PH_MID: begin
          mid_d   = in_data;
          phase_d = PH_LO;
        end
        default: begin
          push    = 1'b1;
          phase_d = PH_HI;
        end
      endcase
    end
  end

  assign push_addr = {hi_q, mid_q, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_HI;
      hi_q    <= '0;
      mid_q   <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
      mid_q   <= mid_d;
    end
  end

  chan_addr_fifo #(
    .W          (AW),
    .DEPTH_LOG2 (QDEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_addr),
    .pop   (pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign pop      = (state_q == ST_IDLE) && ena && !q_empty;
  assign ord_base = sync_stb ? '0 : ord_q;
  assign smp_fire = ((state_q == ST_REQ) && mem_ack && mem_rdy) ||
                    ((state_q == ST_WAIT) && mem_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      smp_data_q <= '0;
      smp_idx_q  <= '0;
      smp_stb_q  <= 1'b0;
      ord_q      <= '0;
    end else begin
      smp_stb_q <= 1'b0;
      ord_q     <= ord_base;
      if (smp_fire) begin
        smp_data_q <= mem_rdata;
        smp_idx_q  <= ord_base;
        smp_stb_q  <= 1'b1;
        ord_q      <= ord_base + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            mem_addr_q <= q_head;
            mem_req_q  <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_rdy ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rdy) state_q <= ST_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as clr_flags wins.
  always_comb begin
    ovf_d  = ovf_q & ~clr_flags;
    late_d = late_q & ~clr_flags;
    if (push && q_full && !pop) ovf_d = 1'b1;
    if (sync_stb && ((state_q != ST_IDLE) || !q_empty)) late_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      late_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      late_q <= late_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign smp_data = smp_data_q;
  assign smp_idx  = smp_idx_q;
  assign smp_stb  = smp_stb_q;
  assign ovf      = ovf_q;
  assign late     = late_q;
endmodule

// File: tb/tb_chan_fetch_sched.sv
// Directed bench for chan_fetch_sched: scripted memory responder, sample/address monitors.
module tb_chan_fetch_sched;
  localparam int AW = 22;
  localparam int IDXW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic            sync_stb = 1'b0;
  logic [7:0]      in_data = '0;
  logic            in_stb_addr = 1'b0;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ack = 1'b0;
  logic            mem_rdy = 1'b0;
  logic [7:0]      mem_rdata = '0;
  logic [7:0]      smp_data;
  logic [IDXW-1:0] smp_idx;
  logic            smp_stb;
  logic            ovf, late;
  logic            clr_flags = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  bit ack_en = 1'b0;
  int ack_dly = 0;
  int rdy_dly = 1;

  logic [AW-1:0]   addr_q[$];
  logic [12:0]     smp_q[$];
  logic            req_prev = 1'b0;

  chan_fetch_sched dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sync_stb(sync_stb),
    .in_data(in_data), .in_stb_addr(in_stb_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .smp_data(smp_data), .smp_idx(smp_idx), .smp_stb(smp_stb),
    .ovf(ovf), .late(late), .clr_flags(clr_flags)
  );

  always #21 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitors sample on the falling edge.
  always @(negedge clk) begin
    if (smp_stb) smp_q.push_back({smp_idx, smp_data});
    if (mem_req && !req_prev) addr_q.push_back(mem_addr);
    req_prev <= mem_req;
  end

  // Memory responder: data is the low address byte plus 0x73.
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(posedge clk); #1;
      if (mem_req && ack_en && rst_n) begin
        a = mem_addr;
        for (int i = 0; i < ack_dly; i++) begin @(posedge clk); #1; end
        mem_ack = 1'b1;
        if (rdy_dly == 0) begin mem_rdy = 1'b1; mem_rdata = a[7:0] + 8'h73; end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdy = 1'b0;
        if (rdy_dly > 0) begin
          for (int i = 1; i < rdy_dly; i++) begin @(posedge clk); #1; end
          mem_rdy = 1'b1; mem_rdata = a[7:0] + 8'h73;
          @(posedge clk); #1;
          mem_rdy = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #5;
    rst_n = 1'b0;
    ena = 1'b0; sync_stb = 1'b0; in_stb_addr = 1'b0; clr_flags = 1'b0; ack_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    addr_q.delete();
    smp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s);
    @(posedge clk); #1;
    in_data = b; in_stb_addr = 1'b1; sync_stb = s;
    @(posedge clk); #1;
    in_stb_addr = 1'b0; sync_stb = 1'b0;
  endtask

  task automatic send_addr(input logic [AW-1:0] a);
    send_byte({2'b00, a[21:16]}, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
  endtask

  task automatic pulse_sync(input logic clr);
    @(posedge clk); #1;
    sync_stb = 1'b1; clr_flags = clr;
    @(posedge clk); #1;
    sync_stb = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic wait_req(input logic v, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_req !== v && n < 100);
    chk(tag, mem_req, v);
  endtask

  task automatic wait_smp(input int n, input string tag);
    int c;
    c = 0;
    while (smp_q.size() < n && c < 300) begin @(negedge clk); c++; end
    repeat (10) @(negedge clk);
    chk(tag, smp_q.size(), n);
  endtask

  initial begin
    logic [12:0] s;
    do_reset();
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_smp", {smp_stb, smp_idx, smp_data}, 0);
    chk("rst_flags", {ovf, late}, 0);

    // Single fetch: ack 2 cycles after req, data 3 cycles after ack.
    ena = 1'b1; ack_en = 1'b1; ack_dly = 2; rdy_dly = 3;
    send_byte(8'hC5, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk);
    chk("t1_req_not_yet", mem_req, 0);
    @(negedge clk);
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 22'h051234);
    wait_smp(1, "t1_nsmp");
    s = (smp_q.size() > 0) ? smp_q[0] : '0;
    chk("t1_smp", s, {5'd0, 8'hA7});

    // Overflow: ack held off, six addresses.
    do_reset();
    ena = 1'b1; ack_en = 1'b0; ack_dly = 1; rdy_dly = 1;
    for (int i = 0; i < 5; i++) send_addr(22'h020010 + 22'(i));
    @(negedge clk);
    chk("t2_ovf_pre", ovf, 0);
    send_addr(22'h020015);
    @(negedge clk);
    chk("t2_ovf", ovf, 1);
    chk("t2_req_held", mem_req, 1);
    ack_en = 1'b1;
    wait_smp(5, "t2_nsmp");
    for (int i = 0; i < 5; i++) begin
      s = (smp_q.size() > i) ? smp_q[i] : '0;
      chk($sformatf("t2_smp%0d", i), s, {5'(i), 8'h83 + 8'(i)});
    end
    chk("t2_naddr", addr_q.size(), 5);

    // Frame boundary and sync coincident with a byte.
    do_reset();
    ena = 1'b1; ack_en = 1'b1; ack_dly = 0; rdy_dly = 1;
    send_byte(8'h3F, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_sync(1'b0);
    @(negedge clk);
    chk("t3_late_idle", late, 0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h03, 1'b1);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    wait_smp(3, "t3_nsmp");
    chk("t3_a0", (addr_q.size() > 0) ? addr_q[0] : '0, 22'h010010);
    chk("t3_a1", (addr_q.size() > 1) ? addr_q[1] : '0, 22'h00ABCD);
    chk("t3_a2", (addr_q.size() > 2) ? addr_q[2] : '0, 22'h034455);

    // Late: sync while WAIT, then clear, then clear colliding with a new late event.
    do_reset();
    ena = 1'b1; ack_en = 1'b1; ack_dly = 0; rdy_dly = 4;
    send_addr(22'h001100);
    wait_smp(1, "t4_nsmp0");
    send_addr(22'h001101);
    wait_req(1'b1, "t4_req");
    wait_req(1'b0, "t4_in_wait");
    pulse_sync(1'b0);
    @(negedge clk);
    chk("t4_late", late, 1);
    wait_smp(2, "t4_nsmp1");
    s = (smp_q.size() > 1) ? smp_q[1] : '0;
    chk("t4_smp_idx0", s, {5'd0, 8'h74});
    @(posedge clk); #1; clr_flags = 1'b1;
    @(posedge clk); #1; clr_flags = 1'b0;
    @(negedge clk);
    chk("t4_clr", late, 0);
    send_addr(22'h001102);
    wait_req(1'b1, "t4_req2");
    wait_req(1'b0, "t4_in_wait2");
    pulse_sync(1'b1);
    @(negedge clk);
    chk("t4_set_wins", late, 1);

    // Ack and rdy in the same cycle, four queued addresses.
    do_reset();
    ena = 1'b1; ack_en = 1'b0; ack_dly = 0; rdy_dly = 0;
    for (int i = 0; i < 4; i++) send_addr(22'h030020 + 22'(i));
    ack_en = 1'b1;
    wait_smp(4, "t5_nsmp");
    for (int i = 0; i < 4; i++) begin
      s = (smp_q.size() > i) ? smp_q[i] : '0;
      chk($sformatf("t5_smp%0d", i), s, {5'(i), 8'h93 + 8'(i)});
    end

    // Async reset during REQ, then ena gating.
    do_reset();
    ena = 1'b1; ack_en = 1'b0;
    send_addr(22'h2ABCDE);
    wait_req(1'b1, "t6_req");
    #5 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_out", {smp_stb, smp_idx, smp_data, ovf, late}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    addr_q.delete();
    smp_q.delete();
    ena = 1'b0; ack_en = 1'b1; ack_dly = 0; rdy_dly = 1;
    send_addr(22'h012345);
    begin
      logic seen;
      seen = 1'b0;
      repeat (10) begin @(negedge clk); seen = seen | mem_req; end
      chk("t6_ena_block", seen, 0);
    end
    ena = 1'b1;
    wait_req(1'b1, "t6_ena_req");
    chk("t6_ena_addr", mem_addr, 22'h012345);
    wait_smp(1, "t6_nsmp");
    s = (smp_q.size() > 0) ? smp_q[0] : '0;
    chk("t6_smp", s, {5'd0, 8'hB8});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
